cache_port_arbiter: RTL and testbench

// - Shares the single L1 cache/memory request port between the Mem stage (D-side: loads/stores)
//   and the fetch stage (I-side: instruction reads). One transaction is outstanding at a time.
// - Sits between the pipeline stages and the cache. It registers the winning request onto the
//   m_* port and routes m_ack/m_rdata back to the owner. D-side has priority; I-side is protected

---
 rtl/sparc_mem_pkg.sv | 30 +++
 rtl/cache_port_arbiter.sv | 109 ++++++++++
 tb/tb_cache_port_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sparc_mem_pkg.sv
// Shared types for the L1 request-port arbiter: arbiter states, the cache request
// record and the grant-selection function.
package sparc_mem_pkg;

  localparam int unsigned LINE_ADDR_W = 58;
  localparam int unsigned WORD_SEL_W  = 4;
  localparam int unsigned DATA_W      = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_D,
    BUSY_I
  } arb_state_t;

  typedef struct packed {
    logic [LINE_ADDR_W-1:0] line_addr;
    logic [WORD_SEL_W-1:0]  word_select;
    logic [DATA_W-1:0]      wdata;
    logic                   read_write_n;
  } mem_req_t;

  // D-side wins unless both are pending and I has already waited its full quota.
  function automatic arb_state_t pick_winner(input logic d_req, input logic i_req,
                                             input logic starved);
    if (d_req && !(i_req && starved)) return BUSY_D;
    else if (i_req)                   return BUSY_I;
    else                              return IDLE;
  endfunction

endpackage

// File: rtl/cache_port_arbiter.sv
// Shares the single L1 request port between the D-side (Mem stage) and I-side (fetch),
// one outstanding transaction at a time, D priority with I starvation protection.
import sparc_mem_pkg::*;

module cache_port_arbiter #(
  parameter int unsigned LINE_ADDR_W = sparc_mem_pkg::LINE_ADDR_W,
  parameter int unsigned WORD_SEL_W  = sparc_mem_pkg::WORD_SEL_W,
  parameter int unsigned DATA_W      = sparc_mem_pkg::DATA_W,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   d_req,
  input  logic [LINE_ADDR_W-1:0] d_line_addr,
  input  logic [WORD_SEL_W-1:0]  d_word_select,
  input  logic [DATA_W-1:0]      d_wdata,
  input  logic                   d_read_write_n,
  output logic                   d_ack,
  output logic [DATA_W-1:0]      d_rdata,
  input  logic                   i_req,
  input  logic [LINE_ADDR_W-1:0] i_line_addr,
  input  logic [WORD_SEL_W-1:0]  i_word_select,
  output logic                   i_ack,
  output logic [DATA_W-1:0]      i_rdata,
  output logic                   m_req,
  output logic [LINE_ADDR_W-1:0] m_line_addr,
  output logic [WORD_SEL_W-1:0]  m_word_select,
  output logic [DATA_W-1:0]      m_wdata,
  output logic                   m_read_write_n,
  input  logic                   m_ack,
  input  logic [DATA_W-1:0]      m_rdata,
  output logic                   err_spurious_ack
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_t state, state_next;
  logic [3:0] starve_cnt;
  logic       starved;

  always_comb begin
    starved    = (starve_cnt == STARVE_LIM);
    state_next = state;
    d_ack      = 1'b0;
    i_ack      = 1'b0;
    d_rdata    = '0;
    i_rdata    = '0;
    case (state)
      IDLE:   state_next = pick_winner(d_req, i_req, starved);
      BUSY_D: begin
        d_rdata = m_rdata;
        if (m_ack) begin
          d_ack      = 1'b1;
          state_next = IDLE;
        end
      end
      BUSY_I: begin
        i_rdata = m_rdata;
        if (m_ack) begin
          i_ack      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      starve_cnt       <= '0;
      m_req            <= 1'b0;
      m_line_addr      <= '0;
      m_word_select    <= '0;
      m_wdata          <= '0;
      m_read_write_n   <= 1'b1;
      err_spurious_ack <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        if (m_ack) err_spurious_ack <= 1'b1;
        // Grant edge: capture the winner; m_* then stay frozen until its ack.
        case (state_next)
          BUSY_D: begin
            m_req          <= 1'b1;
            m_line_addr    <= d_line_addr;
            m_word_select  <= d_word_select;
            m_wdata        <= d_wdata;
            m_read_write_n <= d_read_write_n;
            if (!i_req)       starve_cnt <= '0;
            else if (!starved) starve_cnt <= starve_cnt + 4'd1;
          end
          BUSY_I: begin
            m_req          <= 1'b1;
            m_line_addr    <= i_line_addr;
            m_word_select  <= i_word_select;
            m_wdata        <= '0;
            m_read_write_n <= 1'b1;
            starve_cnt     <= '0;
          end
          default: ;
        endcase
      end else if (m_ack) begin
        m_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction-level model of the arbitration rules.
module tb_cache_port_arbiter;
  import sparc_mem_pkg::*;

  localparam int unsigned STARVE_MAX = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   d_req, d_read_write_n, i_req, m_ack;
  logic [LINE_ADDR_W-1:0] d_line_addr, i_line_addr;
  logic [WORD_SEL_W-1:0]  d_word_select, i_word_select;
  logic [DATA_W-1:0]      d_wdata, m_rdata;
  logic                   d_ack, i_ack, m_req, m_read_write_n, err_spurious_ack;
  logic [DATA_W-1:0]      d_rdata, i_rdata, m_wdata;
  logic [LINE_ADDR_W-1:0] m_line_addr;
  logic [WORD_SEL_W-1:0]  m_word_select;

  cache_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .d_req(d_req), .d_line_addr(d_line_addr), .d_word_select(d_word_select),
    .d_wdata(d_wdata), .d_read_write_n(d_read_write_n), .d_ack(d_ack), .d_rdata(d_rdata),
    .i_req(i_req), .i_line_addr(i_line_addr), .i_word_select(i_word_select),
    .i_ack(i_ack), .i_rdata(i_rdata),
    .m_req(m_req), .m_line_addr(m_line_addr), .m_word_select(m_word_select),
    .m_wdata(m_wdata), .m_read_write_n(m_read_write_n), .m_ack(m_ack), .m_rdata(m_rdata),
    .err_spurious_ack(err_spurious_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: who owns the port (0 none, 1 D, 2 I), the request in
  // flight, how many D grants in a row have passed over a waiting I, and the error flag.
  int       owner = 0;
  int       d_streak = 0;
  mem_req_t cur;
  logic     model_err = 1'b0;
  logic     model_valid = 1'b0;
  logic     d_acked = 1'b0, i_acked = 1'b0;

  always begin
    logic exp_d_ack, exp_i_ack;
    @(negedge clk);
    #2;
    exp_d_ack = (owner == 1) && m_ack;
    exp_i_ack = (owner == 2) && m_ack;
    if (model_valid) begin
      check("m_req", 64'(m_req), 64'(owner != 0));
      if (owner != 0) begin
        check("m_line_addr", 64'(m_line_addr), 64'(cur.line_addr));
        check("m_word_select", 64'(m_word_select), 64'(cur.word_select));
        check("m_wdata", 64'(m_wdata), 64'(cur.wdata));
        check("m_read_write_n", 64'(m_read_write_n), 64'(cur.read_write_n));
      end
      check("d_ack", 64'(d_ack), 64'(exp_d_ack));
      check("i_ack", 64'(i_ack), 64'(exp_i_ack));
      if (exp_d_ack) check("d_rdata", 64'(d_rdata), 64'(m_rdata));
      else if (owner != 1) check("d_rdata_zero", 64'(d_rdata), 64'd0);
      if (exp_i_ack) check("i_rdata", 64'(i_rdata), 64'(m_rdata));
      else if (owner != 2) check("i_rdata_zero", 64'(i_rdata), 64'd0);
      check("err_spurious_ack", 64'(err_spurious_ack), 64'(model_err));
    end
    d_acked = exp_d_ack;
    i_acked = exp_i_ack;
    if (reset) begin
      owner = 0; d_streak = 0; model_err = 1'b0; model_valid = 1'b1;
    end else if (owner != 0) begin
      if (m_ack) owner = 0;
    end else begin
      if (m_ack) model_err = 1'b1;
      if (d_req && !(i_req && d_streak >= STARVE_MAX)) begin
        owner = 1;
        cur = '{line_addr: d_line_addr, word_select: d_word_select,
                wdata: d_wdata, read_write_n: d_read_write_n};
        d_streak = i_req ? ((d_streak + 1 > STARVE_MAX) ? STARVE_MAX : d_streak + 1) : 0;
      end else if (i_req) begin
        owner = 2;
        cur = '{line_addr: i_line_addr, word_select: i_word_select,
                wdata: '0, read_write_n: 1'b1};
        d_streak = 0;
      end
    end
  end

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    next_cycle();
    reset = 1'b1; d_req = 1'b0; i_req = 1'b0; m_ack = 1'b0;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic new_d();
    d_req          = 1'b1;
    d_line_addr    = LINE_ADDR_W'({$urandom(), $urandom()});
    d_word_select  = WORD_SEL_W'($urandom());
    d_wdata        = $urandom();
    d_read_write_n = 1'($urandom_range(0, 1));
  endtask

  task automatic new_i();
    i_req         = 1'b1;
    i_line_addr   = LINE_ADDR_W'({$urandom(), $urandom()});
    i_word_select = WORD_SEL_W'($urandom());
  endtask

  string grant_log = "";
  string exp_seq   = "DDDDID";

  initial begin
    reset = 1'b1;
    d_req = 1'b0; d_line_addr = '0; d_word_select = '0; d_wdata = '0; d_read_write_n = 1'b1;
    i_req = 1'b0; i_line_addr = '0; i_word_select = '0;
    m_ack = 1'b0; m_rdata = '0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    #1;
    check("rst_m_req", 64'(m_req), 64'd0);
    check("rst_m_rw_n", 64'(m_read_write_n), 64'd1);
    check("rst_m_line", 64'(m_line_addr), 64'd0);
    check("rst_err", 64'(err_spurious_ack), 64'd0);

    // D load alone
    next_cycle();
    d_req = 1'b1; d_line_addr = 58'h1; d_word_select = 4'd3; d_read_write_n = 1'b1; d_wdata = '0;
    next_cycle(); #1;
    check("load_m_req", 64'(m_req), 64'd1);
    check("load_m_line", 64'(m_line_addr), 64'h1);
    check("load_m_word", 64'(m_word_select), 64'd3);
    next_cycle(); next_cycle();
    next_cycle(); m_ack = 1'b1; m_rdata = 32'hDEADBEEF; #1;
    check("load_d_ack", 64'(d_ack), 64'd1);
    check("load_d_rdata", 64'(d_rdata), 64'hDEADBEEF);
    next_cycle(); d_req = 1'b0; m_ack = 1'b0; #1;
    check("load_m_req_drop", 64'(m_req), 64'd0);

    // D store
    next_cycle();
    d_req = 1'b1; d_line_addr = 58'h2; d_word_select = 4'hA; d_read_write_n = 1'b0;
    d_wdata = 32'hCAFEF00D;
    next_cycle(); #1;
    check("store_rw_n", 64'(m_read_write_n), 64'd0);
    check("store_wdata", 64'(m_wdata), 64'hCAFEF00D);
    next_cycle(); m_ack = 1'b1; m_rdata = '0; #1;
    check("store_d_ack", 64'(d_ack), 64'd1);
    check("store_i_ack", 64'(i_ack), 64'd0);
    next_cycle(); d_req = 1'b0; m_ack = 1'b0; d_read_write_n = 1'b1;

    // Simultaneous requests from reset: D first, then I
    do_reset();
    d_req = 1'b1; d_line_addr = 58'h10; d_word_select = '0; d_read_write_n = 1'b1;
    i_req = 1'b1; i_line_addr = 58'h5; i_word_select = 4'd1;
    next_cycle(); #1;
    check("both_first_line", 64'(m_line_addr), 64'h10);
    next_cycle(); m_ack = 1'b1; m_rdata = 32'h1111; #1;
    check("both_d_ack", 64'(d_ack), 64'd1);
    check("both_i_ack_low", 64'(i_ack), 64'd0);
    next_cycle(); d_req = 1'b0; m_ack = 1'b0;
    next_cycle(); #1;
    check("both_i_line", 64'(m_line_addr), 64'h5);
    check("both_i_rw_n", 64'(m_read_write_n), 64'd1);
    check("both_i_wdata", 64'(m_wdata), 64'd0);
    next_cycle(); m_ack = 1'b1; m_rdata = 32'h12345678; #1;
    check("both_i_ack", 64'(i_ack), 64'd1);
    check("both_i_rdata", 64'(i_rdata), 64'h12345678);
    check("both_d_rdata_zero", 64'(d_rdata), 64'd0);
    next_cycle(); i_req = 1'b0; m_ack = 1'b0;

    // Starvation: D re-requests back-to-back while I waits
    do_reset();
    i_req = 1'b1; i_line_addr = 58'h200; i_word_select = 4'd2;
    for (int g = 0; g < 6; g++) begin
      d_req = 1'b1; d_line_addr = LINE_ADDR_W'(32'h100 + g); d_read_write_n = 1'b1;
      i_req = 1'b1; m_ack = 1'b0;
      next_cycle();
      next_cycle(); m_ack = 1'b1; m_rdata = DATA_W'(g); #1;
      grant_log = {grant_log, d_ack ? "D" : (i_ack ? "I" : "-")};
      next_cycle();
    end
    for (int k = 0; k < 6; k++) check("starve_seq", 64'(grant_log[k]), 64'(exp_seq[k]));
    d_req = 1'b0; i_req = 1'b0; m_ack = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      if (d_req) begin
        if (d_acked) begin
          if ($urandom_range(0, 1) == 1) new_d(); else d_req = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) new_d();
      if (i_req) begin
        if (i_acked) begin
          if ($urandom_range(0, 1) == 1) new_i(); else i_req = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) new_i();
      m_rdata = $urandom();
      m_ack   = (owner != 0) && ($urandom_range(0, 2) == 0);
    end
    next_cycle();
    d_req = 1'b0; i_req = 1'b0; m_ack = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    next_cycle();

    // Reset in BUSY_D, then a spurious ack in IDLE
    next_cycle(); d_req = 1'b1; d_line_addr = 58'h3; d_read_write_n = 1'b1;
    next_cycle(); #1;
    check("rbusy_m_req", 64'(m_req), 64'd1);
    reset = 1'b1; d_req = 1'b0;
    next_cycle(); reset = 1'b0; #1;
    check("rbusy_m_req_clr", 64'(m_req), 64'd0);
    check("rbusy_d_ack", 64'(d_ack), 64'd0);
    next_cycle(); m_ack = 1'b1; m_rdata = 32'hBAD0BAD0; #1;
    check("spur_d_ack", 64'(d_ack), 64'd0);
    check("spur_i_ack", 64'(i_ack), 64'd0);
    next_cycle(); m_ack = 1'b0; #1;
    check("spur_err", 64'(err_spurious_ack), 64'd1);
    next_cycle();
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
